// File: rtl/dff_err_snapshot_tx.sv
// Snapshots N_CH 32-bit DFF error counters on a Pi save request and shifts them
// out serially (header, counters MSB first, CRC-8) under a Pi-driven bit clock.
module dff_err_snapshot_tx #(
  parameter int unsigned N_CH        = 14,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                CLK,
  input  logic                RST_B,
  input  logic                SAVE_REQ,
  input  logic                SHIFT_CLK,
  input  logic [32*N_CH-1:0]  ERR_CNT_FLAT,
  output logic                DATA_OUT,
  output logic                BUSY,
  output logic                FRAME_DONE
);

  localparam int unsigned FLAT_W     = 32 * N_CH;
  localparam int unsigned FRAME_BITS = FLAT_W + 16;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned IDX_W      = $clog2(FLAT_W);

  localparam logic [CNT_W-1:0] DATA_START = CNT_W'(8);
  localparam logic [CNT_W-1:0] CRC_START  = CNT_W'(8 + FLAT_W);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Synchronizers, edge detectors and the post-reset arming of SAVE_REQ
  logic [SYNC_STAGES-1:0] save_sync_q, save_sync_d;
  logic [SYNC_STAGES-1:0] shift_sync_q, shift_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   save_prev_q, save_prev_d;
  logic                   shift_prev_q, shift_prev_d;
  logic                   save_armed_q, save_armed_d;
  logic                   save_edge_q, save_edge_d;
  logic                   shift_edge_q, shift_edge_d;

  // Frame state
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             crc_q, crc_d;
  logic [FLAT_W-1:0]      shadow_q, shadow_d;

  // Registered outputs
  logic                   data_out_q, data_out_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;

  // Datapath helpers
  logic [CNT_W-1:0]       data_off;
  logic [IDX_W-1:0]       data_idx;
  logic                   in_data;
  logic                   cur_bit;
  logic [7:0]             crc_next;

  // NOTE: every signal assigned in an always_comb gets a default value at the
  // top of the block so no path can leave it unassigned and infer a latch.
  always_comb begin
    save_sync_d  = {save_sync_q[SYNC_STAGES-2:0], SAVE_REQ};
    shift_sync_d = {shift_sync_q[SYNC_STAGES-2:0], SHIFT_CLK};
    fill_d       = {fill_q[SYNC_STAGES-2:0], 1'b1};
    save_prev_d  = save_sync_q[SYNC_STAGES-1];
    shift_prev_d = shift_sync_q[SYNC_STAGES-1];
    // A level already high at reset release is not an edge: only a genuinely
    // sampled low (fill chain complete) arms the save detector.
    save_armed_d = save_armed_q | (fill_q[SYNC_STAGES-1] & ~save_sync_q[SYNC_STAGES-1]);
    save_edge_d  = save_armed_q & save_sync_q[SYNC_STAGES-1] & ~save_prev_q;
    shift_edge_d = shift_sync_q[SYNC_STAGES-1] & ~shift_prev_q;
  end

  // Bit selection: header and CRC boundaries are byte aligned, so cnt[2:0]
  // picks the bit MSB first; inverting the low five offset bits maps the data
  // position onto the MSB-first bit of the current 32-bit channel.
  always_comb begin
    data_off = cnt_q - DATA_START;
    data_idx = data_off[IDX_W-1:0] ^ IDX_W'(31);
    in_data  = (cnt_q >= DATA_START) && (cnt_q < CRC_START);
    cur_bit  = 1'b0;
    if (cnt_q < DATA_START) begin
      cur_bit = HEADER[~cnt_q[2:0]];
    end else if (in_data) begin
      cur_bit = shadow_q[data_idx];
    end else begin
      cur_bit = crc_q[~cnt_q[2:0]];
    end
    crc_next = {crc_q[6:0], 1'b0} ^ ({8{crc_q[7] ^ cur_bit}} & 8'h07);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    shadow_d = shadow_q;
    unique case (state_q)
      IDLE: begin
        // A coincident shift edge is simply not looked at here.
        if (save_edge_q) begin
          shadow_d = ERR_CNT_FLAT;
          cnt_d    = '0;
          crc_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_edge_q) begin
          if (in_data) begin
            crc_d = crc_next;
          end
          if (cnt_q == LAST_BIT) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    data_out_d   = (state_q == SHIFT) & cur_bit;
    busy_d       = (state_q != IDLE);
    frame_done_d = (state_q == DONE);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      save_sync_q  <= '0;
      shift_sync_q <= '0;
      fill_q       <= '0;
      save_prev_q  <= 1'b0;
      shift_prev_q <= 1'b0;
      save_armed_q <= 1'b0;
      save_edge_q  <= 1'b0;
      shift_edge_q <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      crc_q        <= '0;
      // NOTE: the shadow register is reset on purpose: a frame aborted by reset
      // must never leak a stale snapshot, so it is cleared like any control flop.
      shadow_q     <= '0;
      data_out_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      save_sync_q  <= save_sync_d;
      shift_sync_q <= shift_sync_d;
      fill_q       <= fill_d;
      save_prev_q  <= save_prev_d;
      shift_prev_q <= shift_prev_d;
      save_armed_q <= save_armed_d;
      save_edge_q  <= save_edge_d;
      shift_edge_q <= shift_edge_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      shadow_q     <= shadow_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign DATA_OUT   = data_out_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frame_done_q;

endmodule
